// File: rtl/spi_fifo_sequencer.sv
// SPI mode-0 master that drains a TX FIFO word by word, shifts each word out MSB first
// and pushes the word captured from MISO into an RX FIFO. All outputs come straight from flops.
module spi_fifo_sequencer #(
  parameter int WIDTH  = 32,
  parameter int DIV    = 4,
  parameter int CS_GAP = 2
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Enable,
  input  logic             Burst,
  input  logic             ClearOV,
  input  logic [WIDTH-1:0] TxData,
  input  logic             TxEmpty,
  output logic             TxRead,
  output logic [WIDTH-1:0] RxData,
  input  logic             RxFull,
  output logic             RxWrite,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             CS_n,
  output logic             Busy,
  output logic             Done,
  output logic             RxOverrun
);

  localparam int CW = 16;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SETUP = 3'd3,
    S_SHIFT = 3'd4,
    S_HOLD  = 3'd5,
    S_PUSH  = 3'd6,
    S_GAP   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             tx_read_q, tx_read_d;
  logic             rx_write_q, rx_write_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  // Next-state and next-output logic; outputs are decided one edge ahead so they can be registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    tx_read_d  = 1'b0;
    rx_write_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Enable && !TxEmpty) begin
          state_d   = S_FETCH;
          tx_read_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_SETUP;
        cnt_d   = DIV_LAST;
        tx_d    = TxData;
      end
      S_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_SHIFT;
          cnt_d   = DIV_LAST;
          bit_d   = BIT_ZERO;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[WIDTH-2:0], MISO};
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SHIFT: begin
        // Each half-period lasts DIV cycles; the word ends after the low phase following the last fall.
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (sclk_q) begin
          sclk_d = 1'b0;
          tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          bit_d  = bit_q + BIT_ONE;
          cnt_d  = DIV_LAST;
        end else if (bit_q == BIT_LAST) begin
          state_d = S_HOLD;
          cnt_d   = DIV_LAST;
        end else begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[WIDTH-2:0], MISO};
          cnt_d  = DIV_LAST;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d    = S_PUSH;
          rx_data_d  = rx_q;
          done_d     = 1'b1;
          rx_write_d = !RxFull;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PUSH: begin
        if (Burst && Enable && !TxEmpty) begin
          state_d   = S_FETCH;
          tx_read_d = 1'b1;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LAST;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A FETCH keeps whatever CS_n level it inherits: high from IDLE/GAP, low inside a burst.
    case (state_d)
      S_IDLE, S_GAP: cs_n_d = 1'b1;
      S_FETCH:       cs_n_d = cs_n_q;
      default:       cs_n_d = 1'b0;
    endcase

    busy_d = (state_d != S_IDLE);

    if (state_q == S_PUSH && !rx_write_q) begin
      overrun_d = 1'b1;
    end else if (ClearOV) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      bit_q      <= BIT_ZERO;
      tx_q       <= {WIDTH{1'b0}};
      rx_q       <= {WIDTH{1'b0}};
      rx_data_q  <= {WIDTH{1'b0}};
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_read_q  <= 1'b0;
      rx_write_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      tx_read_q  <= tx_read_d;
      rx_write_q <= rx_write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign TxRead    = tx_read_q;
  assign RxWrite   = rx_write_q;
  assign RxData    = rx_data_q;
  assign SCLK      = sclk_q;
  assign MOSI      = tx_q[WIDTH-1];
  assign CS_n      = cs_n_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign RxOverrun = overrun_q;

endmodule
